pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/hazard_pipe_track.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: tracker entry, multicycle FSM states, defaults.
// The HAZ_MC_EN build macro selects the multicycle stall unit in pipe_hazard_ctrl.
package hazard_pkg;
    localparam int DEF_REG_AW     = 6;
    localparam int DEF_FWD_STAGES = 2;
    localparam int DEF_MAX_LAT    = 8;
    // Entry rd field is sized for the widest supported register space; REG_AW must not exceed it.
    localparam int RD_MAX_W       = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                wb;
        logic                load;
    } entry_t;

    typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_e;

    // Integer x0 never produces a value; FP f0 (bit 5 set) is a real register.
    function automatic logic ent_hit(entry_t e, logic [RD_MAX_W-1:0] src, logic rd_used);
        return rd_used & e.valid & e.wb & (e.rd == src) & (e.rd != '0);
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between the pipeline and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW     = 6,
    parameter int FWD_STAGES = 2,
    parameter int MAX_LAT    = 8
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_rs1_use, id_rs2_use;
    logic [REG_AW-1:0] id_rd;
    logic              id_wb, id_load, id_mc;
    logic [LAT_W-1:0]  id_mc_lat;
    logic              ex_redirect;
    logic              stall_if, stall_id, flush_id, bubble_ex;
    logic [SEL_W-1:0]  fwd1_sel, fwd2_sel;
    logic              rf_byp1, rf_byp2, mc_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_wb, id_load,
               id_mc, id_mc_lat, ex_redirect,
        input  stall_if, stall_id, flush_id, bubble_ex, fwd1_sel, fwd2_sel,
               rf_byp1, rf_byp2, mc_busy
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_wb, id_load,
               id_mc, id_mc_lat, ex_redirect,
        output stall_if, stall_id, flush_id, bubble_ex, fwd1_sel, fwd2_sel,
               rf_byp1, rf_byp2, mc_busy
    );
endinterface

// File: rtl/hazard_pipe_track.sv
// Destination tracker for positions 1 (EX) .. FWD_STAGES (WB) plus per-position source match vectors.
module hazard_pipe_track
    import hazard_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int FWD_STAGES = DEF_FWD_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  entry_t                ent_in,
    input  logic [REG_AW-1:0]     rs1,
    input  logic [REG_AW-1:0]     rs2,
    input  logic                  use1,
    input  logic                  use2,
    output logic [FWD_STAGES:1]   m1,
    output logic [FWD_STAGES:1]   m2,
    output logic                  e1_load
);
    entry_t [FWD_STAGES:1] ent;
    logic unused_tail_load;

    // While EX holds a multicycle op, position 1 freezes and a bubble trails it into position 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent <= '0;
        end else begin
            for (int k = FWD_STAGES; k >= 2; k--)
                ent[k] <= (hold && k == 2) ? '0 : ent[k-1];
            if (!hold)
                ent[1] <= ent_in;
        end
    end

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 1; k <= FWD_STAGES; k++) begin
            m1[k] = ent_hit(ent[k], RD_MAX_W'(rs1), use1);
            m2[k] = ent_hit(ent[k], RD_MAX_W'(rs2), use2);
        end
    end

    assign e1_load          = ent[1].load;
    assign unused_tail_load = ent[FWD_STAGES].load;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard control: forwarding selects, load-use and multicycle stalls, redirect flush.
// Define HAZ_MC_EN to build the multicycle busy FSM; otherwise id_mc/id_mc_lat are ignored.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int FWD_STAGES = DEF_FWD_STAGES,
    parameter int MAX_LAT    = DEF_MAX_LAT
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [FWD_STAGES:1] m1, m2;
    logic                e1_load, busy, load_use, advance;
    entry_t              ent_in;

    function automatic logic [SEL_W-1:0] first_hit(logic [FWD_STAGES:1] m);
        first_hit = '0;
        for (int k = FWD_STAGES; k >= 1; k--)
            if (m[k]) first_hit = SEL_W'(k);
    endfunction

    hazard_pipe_track #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_track (
        .clk(clk), .rst(rst), .hold(busy), .ent_in(ent_in),
        .rs1(hz.id_rs1), .rs2(hz.id_rs2), .use1(hz.id_rs1_use), .use2(hz.id_rs2_use),
        .m1(m1), .m2(m2), .e1_load(e1_load)
    );

    assign load_use = hz.id_valid & e1_load & (m1[1] | m2[1]);

    // Redirect beats the multicycle stall, which beats load-use.
    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.flush_id  = 1'b0;
        hz.bubble_ex = 1'b0;
        if (!rst) begin
            if (hz.ex_redirect) begin
                hz.flush_id  = 1'b1;
                hz.bubble_ex = 1'b1;
            end else if (busy) begin
                hz.stall_if = 1'b1;
                hz.stall_id = 1'b1;
            end else if (load_use) begin
                hz.stall_if  = 1'b1;
                hz.stall_id  = 1'b1;
                hz.bubble_ex = 1'b1;
            end
        end
    end

    assign advance = hz.id_valid & ~hz.stall_id & ~hz.flush_id;
    assign ent_in  = '{valid: advance, rd: RD_MAX_W'(hz.id_rd), wb: hz.id_wb, load: hz.id_load};
    assign hz.rf_byp1 = ~rst & m1[FWD_STAGES];
    assign hz.rf_byp2 = ~rst & m2[FWD_STAGES];

    // Selects belong to the op in EX, so they hold while EX is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz.fwd1_sel <= '0;
            hz.fwd2_sel <= '0;
        end else if (!busy) begin
            hz.fwd1_sel <= hz.bubble_ex ? '0 : first_hit(m1);
            hz.fwd2_sel <= hz.bubble_ex ? '0 : first_hit(m2);
        end
    end

`ifdef HAZ_MC_EN
    mc_state_e        state, state_nxt;
    logic [LAT_W-1:0] cnt, cnt_nxt, eff_lat;
    logic             mc_start;

    assign eff_lat  = (hz.id_mc_lat == '0) ? LAT_W'(1) : hz.id_mc_lat;
    assign mc_start = advance & hz.id_mc & (eff_lat > LAT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MC_IDLE: if (mc_start) begin
                state_nxt = MC_BUSY;
                cnt_nxt   = eff_lat - LAT_W'(1);
            end
            MC_BUSY: begin
                cnt_nxt = cnt - LAT_W'(1);
                if (cnt == LAT_W'(1)) state_nxt = MC_IDLE;
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    always_comb busy = (state == MC_BUSY);
    assign hz.mc_busy = busy;

    a_no_redirect_busy: assert property (@(posedge clk) disable iff (rst) !(busy && hz.ex_redirect));
`else
    logic unused_mc;
    assign unused_mc  = ^{hz.id_mc, hz.id_mc_lat};
    assign busy       = 1'b0;
    assign hz.mc_busy = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random + directed bench for pipe_hazard_ctrl against a position-array pipeline model.
module tb_pipe_hazard_ctrl;
    localparam int AW = 6, FS = 2, ML = 8;
    localparam int LW = $clog2(ML + 1);
`ifdef HAZ_MC_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .FWD_STAGES(FS), .MAX_LAT(ML)) hz ();
    pipe_hazard_ctrl #(.REG_AW(AW), .FWD_STAGES(FS), .MAX_LAT(ML)) dut (.clk(clk), .rst(rst), .hz(hz));

    int vecs = 0, errs = 0;
    bit chk_on = 1'b0;

    // Model: what each pipeline position holds, remaining EX hold cycles, registered selects.
    bit          m_v[1:FS], m_wb[1:FS], m_ld[1:FS];
    logic [AW-1:0] m_rd[1:FS];
    int          m_left, m_f1, m_f2;

    task automatic chk(string nm, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(logic [AW-1:0] src, bit u, int k);
        return u && m_v[k] && m_wb[k] && m_rd[k] == src && m_rd[k] != 0;
    endfunction

    function automatic int nearest(logic [AW-1:0] src, bit u);
        for (int k = 1; k <= FS; k++) if (hit(src, u, k)) return k;
        return 0;
    endfunction

    function automatic bit lu_now();
        return hz.id_valid && m_ld[1] &&
               (hit(hz.id_rs1, hz.id_rs1_use, 1) || hit(hz.id_rs2, hz.id_rs2_use, 1));
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= FS; k++) begin
            m_v[k] = 0; m_wb[k] = 0; m_ld[k] = 0; m_rd[k] = '0;
        end
        m_left = 0; m_f1 = 0; m_f2 = 0;
    endtask

    task automatic model_step();
        bit redir, lu, adv;
        int lat;
        if (rst) begin model_reset(); return; end
        if (m_left > 0) begin
            for (int k = FS; k >= 3; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_wb[k] = m_wb[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[2] = 0;
            m_left--;
            return;
        end
        redir = hz.ex_redirect;
        lu    = lu_now();
        if (redir || lu) begin
            m_f1 = 0; m_f2 = 0;
        end else begin
            m_f1 = nearest(hz.id_rs1, hz.id_rs1_use);
            m_f2 = nearest(hz.id_rs2, hz.id_rs2_use);
        end
        adv = !redir && !lu && hz.id_valid;
        for (int k = FS; k >= 2; k--) begin
            m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_wb[k] = m_wb[k-1]; m_ld[k] = m_ld[k-1];
        end
        m_v[1] = adv; m_rd[1] = hz.id_rd; m_wb[1] = hz.id_wb; m_ld[1] = hz.id_load;
        lat = (hz.id_mc_lat == 0) ? 1 : int'(hz.id_mc_lat);
        if (MC_EN && adv && hz.id_mc) m_left = lat - 1;
    endtask

    task automatic compare_all();
        bit r, b, lu, rd;
        r  = rst;
        b  = m_left > 0;
        lu = lu_now();
        rd = hz.ex_redirect;
        chk("stall_if",  hz.stall_if,  int'(!r && !rd && (b || lu)));
        chk("stall_id",  hz.stall_id,  int'(!r && !rd && (b || lu)));
        chk("flush_id",  hz.flush_id,  int'(!r && rd));
        chk("bubble_ex", hz.bubble_ex, int'(!r && (rd || (!b && lu))));
        chk("fwd1_sel",  hz.fwd1_sel,  m_f1);
        chk("fwd2_sel",  hz.fwd2_sel,  m_f2);
        chk("rf_byp1",   hz.rf_byp1,   int'(!r && hit(hz.id_rs1, hz.id_rs1_use, FS)));
        chk("rf_byp2",   hz.rf_byp2,   int'(!r && hit(hz.id_rs2, hz.id_rs2_use, FS)));
        chk("mc_busy",   hz.mc_busy,   int'(b));
    endtask

    always @(negedge clk) if (chk_on) begin
        #3;
        compare_all();
    end

    task automatic set_id(bit v, logic [AW-1:0] r1, bit u1, logic [AW-1:0] r2, bit u2,
                          logic [AW-1:0] rd, bit wb, bit ld, bit mc = 0, int lat = 0, bit redir = 0);
        hz.id_valid = v; hz.id_rs1 = r1; hz.id_rs1_use = u1; hz.id_rs2 = r2; hz.id_rs2_use = u2;
        hz.id_rd = rd; hz.id_wb = wb; hz.id_load = ld; hz.id_mc = mc; hz.id_mc_lat = LW'(lat);
        hz.ex_redirect = redir;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    logic [AW-1:0] pool[6] = '{6'h00, 6'h05, 6'h07, 6'h20, 6'h21, 6'h03};

    initial begin
        model_reset();
        #1 rst = 1'b1;
        set_id(1, 7, 1, 7, 1, 7, 1, 1, 0, 0, 1);
        #2;
        chk("rst_stall_if",  hz.stall_if, 0);
        chk("rst_flush_id",  hz.flush_id, 0);
        chk("rst_bubble_ex", hz.bubble_ex, 0);
        chk("rst_fwd1",      hz.fwd1_sel, 0);
        chk("rst_rf_byp1",   hz.rf_byp1, 0);
        chk("rst_mc_busy",   hz.mc_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        nop();
        chk_on = 1'b1;
        cyc();

        // Back-to-back ALU dependency forwards from EX, then clears.
        set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
        set_id(1, 5, 1, 0, 0, 6, 1, 0); #4; chk("dep_no_stall", hz.stall_if, 0); cyc();
        set_id(1, 9, 1, 0, 0, 10, 1, 0); #4; chk("fwd_ex", hz.fwd1_sel, 1); cyc();
        nop(); #4; chk("fwd_indep", hz.fwd1_sel, 0); cyc();

        // Load-use: one stall+bubble, then forward from position 2.
        cyc(); cyc();
        set_id(1, 0, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 0, 0, 7, 1, 8, 1, 0); #4;
        chk("lu_stall_if", hz.stall_if, 1); chk("lu_stall_id", hz.stall_id, 1);
        chk("lu_bubble", hz.bubble_ex, 1); chk("lu_flush", hz.flush_id, 0); cyc();
        #4; chk("lu_release", hz.stall_if, 0); chk("lu_rf_byp2", hz.rf_byp2, 1);
        chk("lu_fwd_bubble", hz.fwd2_sel, 0); cyc();
        nop(); #4; chk("lu_fwd2", hz.fwd2_sel, 2); cyc();

        // x0 never forwards, f0 does.
        cyc(); cyc();
        set_id(1, 0, 0, 0, 0, 0, 1, 0); cyc();
        set_id(1, 0, 1, 0, 1, 6'h20, 1, 0); #4; chk("x0_no_stall", hz.stall_if, 0); cyc();
        set_id(1, 6'h20, 1, 0, 0, 3, 1, 0); #4;
        chk("x0_fwd1", hz.fwd1_sel, 0); chk("x0_fwd2", hz.fwd2_sel, 0); cyc();
        nop(); #4; chk("f0_fwd1", hz.fwd1_sel, 1); cyc();

        // Redirect overrides a coincident load-use.
        cyc(); cyc();
        set_id(1, 0, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1); #4;
        chk("rd_flush", hz.flush_id, 1); chk("rd_bubble", hz.bubble_ex, 1);
        chk("rd_stall_if", hz.stall_if, 0); chk("rd_stall_id", hz.stall_id, 0); cyc();
        nop(); #4; chk("rd_fwd1", hz.fwd1_sel, 0); cyc();

`ifdef HAZ_MC_EN
        // Latency-4 multiply holds EX for three extra cycles.
        cyc(); cyc();
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 1, 4); cyc();
        set_id(1, 9, 1, 0, 0, 11, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #4; chk("mul_busy", hz.mc_busy, 1); chk("mul_stall", hz.stall_if, 1); cyc();
        end
        #4; chk("mul_done_busy", hz.mc_busy, 0); chk("mul_done_stall", hz.stall_if, 0); cyc();
        nop(); #4; chk("mul_fwd1", hz.fwd1_sel, 1); cyc();

        // Async reset on the second busy cycle.
        cyc(); cyc();
        set_id(1, 0, 0, 0, 0, 12, 1, 0, 1, 5); cyc();
        nop(); cyc();
        #1; chk("busy2_pre_rst", hz.mc_busy, 1);
        rst = 1'b1; model_reset(); #1;
        chk("rst_busy_clr", hz.mc_busy, 0); chk("rst_busy_stall", hz.stall_if, 0);
        chk("rst_busy_stall_id", hz.stall_id, 0); chk("rst_busy_fwd2", hz.fwd2_sel, 0);
        cyc();
        rst = 1'b0;
        cyc();
`endif

        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 9) < 8,
                   pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
                   pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
                   pool[$urandom_range(0, 5)], $urandom_range(0, 3) < 3,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                   int'($urandom_range(0, ML)),
                   (m_left == 0) && ($urandom_range(0, 9) == 0));
            if (n % 150 == 149) begin
                #1 rst = 1'b1;
                model_reset();
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
